// File: rtl/bram_8192x2_port_arbiter.sv
// Round-robin arbiter sharing one port of an 8192x2 block RAM among NREQ clients,
// with an optional zero-fill of the whole array after reset.
module bram_8192x2_port_arbiter #(
  parameter int NREQ           = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [13*NREQ-1:0]   addr,
  input  logic [2*NREQ-1:0]    wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [1:0]           rdata,
  output logic                 busy,
  output logic [12:0]          ram_a,
  output logic [1:0]           ram_d,
  output logic                 ram_we,
  output logic [1:0]           ram_wem,
  output logic                 ram_ce,
  input  logic [1:0]           ram_q
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic {ST_CLEAR, ST_SERVE} state_t;

  state_t          state_reg;
  logic [12:0]     clr_cnt_reg;
  logic [PW-1:0]   rr_ptr_reg;
  logic [NREQ-1:0] pend_reg;

  logic [12:0]     addr_arr  [NREQ];
  logic [1:0]      wdata_arr [NREQ];
  logic            win_valid;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   ptr_next;
  logic            clearing;
  logic            grant;
  int              idx;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr[13*gi +: 13];
      assign wdata_arr[gi] = wdata[2*gi +: 2];
    end
  endgenerate

  // Scan from the farthest slot back to rr_ptr so the nearest requester wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_reg) + k) % NREQ;
      if (req[idx]) begin
        win_valid = 1'b1;
        win_idx   = idx[PW-1:0];
      end
    end
  end

  assign ptr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  assign clearing = !RST && (state_reg == ST_CLEAR);
  assign grant    = !RST && (state_reg == ST_SERVE) && win_valid;
  assign gnt      = grant ? ({{(NREQ-1){1'b0}}, 1'b1} << win_idx) : '0;
  assign busy     = RST ? CLEAR_ON_RESET : (state_reg == ST_CLEAR);
  assign rvalid   = RST ? '0 : pend_reg;
  assign rdata    = ram_q;
  assign ram_wem  = 2'b11;

  always_comb begin
    ram_ce = 1'b0;
    ram_we = 1'b0;
    ram_a  = '0;
    ram_d  = '0;
    if (clearing) begin
      ram_ce = 1'b1;
      ram_we = 1'b1;
      ram_a  = clr_cnt_reg;
    end else if (grant) begin
      ram_ce = 1'b1;
      ram_we = we[win_idx];
      ram_a  = addr_arr[win_idx];
      ram_d  = wdata_arr[win_idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;
      clr_cnt_reg <= '0;
      rr_ptr_reg  <= '0;
      pend_reg    <= '0;
    end else begin
      pend_reg <= '0;
      case (state_reg)
        ST_CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + 13'd1;
          if (clr_cnt_reg == 13'h1FFF) state_reg <= ST_SERVE;
        end
        ST_SERVE: begin
          if (win_valid) begin
            rr_ptr_reg <= ptr_next;
            if (!we[win_idx]) pend_reg <= gnt;
          end
        end
        default: state_reg <= ST_SERVE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_8192x2_port_arbiter.sv
// Self-checking bench: behavioural RAM on the arbiter port plus a reference model
// of the round-robin order, read return and clear phase.
module tb_bram_8192x2_port_arbiter;
  localparam int NREQ = 4;
  localparam bit CLR  = 1'b1;

  logic                CLK = 1'b0;
  logic                RST;
  logic [NREQ-1:0]     req, we;
  logic [13*NREQ-1:0]  addr;
  logic [2*NREQ-1:0]   wdata;
  logic [NREQ-1:0]     gnt, rvalid;
  logic [1:0]          rdata, ram_d, ram_wem, ram_q;
  logic                busy, ram_we, ram_ce;
  logic [12:0]         ram_a;

  bram_8192x2_port_arbiter #(.NREQ(NREQ), .CLEAR_ON_RESET(CLR)) dut (
    .CLK(CLK), .RST(RST), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_wem(ram_wem),
    .ram_ce(ram_ce), .ram_q(ram_q)
  );

  always #5 CLK = ~CLK;

  // RAM device attached to the arbiter port
  logic [1:0] ram [0:8191];
  logic       preload_fill = 1'b0;
  always @(posedge CLK) begin
    if (preload_fill) begin
      for (int i = 0; i < 8192; i++) ram[i] <= 2'b11;
    end else if (ram_ce) begin
      ram_q <= ram[ram_a];
      if (ram_we) ram[ram_a] <= ram_d;
    end
  end

  // Reference model state
  logic [1:0] mem_m [0:8191];
  int         m_ptr, m_pend, m_clear;
  logic [1:0] m_pdata;
  int         checks, failures;

  function automatic int model_winner(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic settle();
    #1;
  endtask

  // Advance one clock and apply the specification's rules to the model.
  task automatic tick();
    int w;
    logic [12:0] a;
    w = (RST || m_clear > 0) ? -1 : model_winner(req, m_ptr);
    @(posedge CLK);
    m_pend = -1;
    if (RST) begin
      m_ptr   = 0;
      m_clear = CLR ? 8192 : 0;
    end else if (m_clear > 0) begin
      mem_m[8192 - m_clear] = 2'b00;
      m_clear--;
    end else if (w >= 0) begin
      a     = addr[13*w +: 13];
      m_ptr = (w + 1) % NREQ;
      if (we[w]) mem_m[a] = wdata[2*w +: 2];
      else begin
        m_pend  = w;
        m_pdata = mem_m[a];
      end
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic w_en, input logic [12:0] a, input logic [1:0] d);
    req[i]            = 1'b1;
    we[i]             = w_en;
    addr[13*i +: 13]  = a;
    wdata[2*i +: 2]   = d;
  endtask

  task automatic test_reset();
    preload_fill = 1'b1;
    @(posedge CLK);
    #1 preload_fill = 1'b0;
    for (int i = 0; i < 8192; i++) mem_m[i] = 2'b11;
    RST = 1'b1;
    req = '1;
    tick();
    tick();
    checks += 7;
    if (gnt !== 4'b0000)  begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    if (rvalid !== 4'b0000) begin failures++; $display("FAIL reset_rvalid got=%b exp=0000", rvalid); end
    if (ram_ce !== 1'b0 || ram_we !== 1'b0) begin failures++; $display("FAIL reset_ce_we got=%b%b exp=00", ram_ce, ram_we); end
    if (ram_a !== 13'd0)  begin failures++; $display("FAIL reset_ram_a got=%h exp=0", ram_a); end
    if (ram_d !== 2'b00)  begin failures++; $display("FAIL reset_ram_d got=%b exp=00", ram_d); end
    if (ram_wem !== 2'b11) begin failures++; $display("FAIL reset_wem got=%b exp=11", ram_wem); end
    if (busy !== CLR)     begin failures++; $display("FAIL reset_busy got=%b exp=%b", busy, CLR); end
    req = '0;
    settle();
  endtask

  task automatic test_clear();
    int n, nwe;
    logic [12:0] tgt [3];
    tgt[0] = 13'd0; tgt[1] = 13'd4095; tgt[2] = 13'd8191;
    RST = 1'b0;
    req = '1;
    settle();
    n = 0; nwe = 0;
    while (busy === 1'b1 && n < 10000) begin
      if (ram_we === 1'b1) nwe++;
      if (gnt !== 4'b0000) begin checks++; failures++; $display("FAIL clear_gnt got=%b exp=0000", gnt); end
      n++;
      tick();
    end
    checks += 2;
    if (n != 8192)   begin failures++; $display("FAIL clear_busy_cycles got=%0d exp=8192", n); end
    if (nwe != 8192) begin failures++; $display("FAIL clear_we_pulses got=%0d exp=8192", nwe); end
    req = '0;
    for (int k = 0; k < 3; k++) begin
      set_req(k, 1'b0, tgt[k], 2'b00);
      settle();
      tick();
      req = '0;
      settle();
      checks++;
      if (rvalid !== (4'b0001 << k) || rdata !== 2'b00) begin
        failures++; $display("FAIL clear_read a=%0d got rvalid=%b rdata=%b exp rvalid=%b rdata=00", tgt[k], rvalid, rdata, 4'b0001 << k);
      end
      $display("txn clear_read addr=%0d rdata=%b", tgt[k], rdata);
    end
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 13'h1ABC, 2'b10);
    settle();
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL single_wr_gnt got=%b exp=0001", gnt); end
    tick();
    req = '0;
    set_req(0, 1'b0, 13'h1ABC, 2'b00);
    settle();
    checks += 2;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL single_rd_gnt got=%b exp=0001", gnt); end
    if (rvalid !== 4'b0000) begin failures++; $display("FAIL single_wr_rvalid got=%b exp=0000", rvalid); end
    tick();
    req = '0;
    settle();
    checks++;
    if (rvalid !== 4'b0001 || rdata !== 2'b10) begin
      failures++; $display("FAIL single_rdata got rvalid=%b rdata=%b exp rvalid=0001 rdata=10", rvalid, rdata);
    end
    $display("txn single addr=1abc rdata=%b", rdata);
  endtask

  task automatic test_round_robin();
    int cnt [NREQ];
    int prev;
    set_req(3, 1'b0, 13'd3, 2'b00);   // leaves the pointer at 0
    settle();
    tick();
    req = '0;
    for (int i = 0; i < NREQ; i++) begin
      cnt[i] = 0;
      set_req(i, 1'b0, 13'($urandom_range(0, 8191)), 2'b00);
    end
    prev = 3;
    for (int c = 0; c < 8; c++) begin
      settle();
      checks += 2;
      if (gnt !== (4'b0001 << (c % 4))) begin failures++; $display("FAIL rr_order c=%0d got=%b exp=%b", c, gnt, 4'b0001 << (c % 4)); end
      if (rvalid !== (4'b0001 << prev) || rdata !== m_pdata) begin
        failures++; $display("FAIL rr_rvalid c=%0d got rvalid=%b rdata=%b exp rvalid=%b rdata=%b", c, rvalid, rdata, 4'b0001 << prev, m_pdata);
      end
      for (int i = 0; i < NREQ; i++) if (gnt[i] === 1'b1) cnt[i]++;
      $display("txn rr c=%0d gnt=%b rvalid=%b", c, gnt, rvalid);
      prev = c % 4;
      tick();
    end
    req = '0;
    settle();
    checks++;
    if (rvalid !== 4'b1000) begin failures++; $display("FAIL rr_last_rvalid got=%b exp=1000", rvalid); end
    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (cnt[i] != 2) begin failures++; $display("FAIL rr_count req=%0d got=%0d exp=2", i, cnt[i]); end
    end
  endtask

  task automatic test_pointer_skip();
    set_req(0, 1'b1, 13'd100, 2'b01);  // leaves the pointer at 1
    settle();
    tick();
    req = '0;
    set_req(0, 1'b0, 13'd100, 2'b00);
    set_req(3, 1'b0, 13'd100, 2'b00);
    settle();
    checks++;
    if (gnt !== 4'b1000) begin failures++; $display("FAIL skip_first got=%b exp=1000", gnt); end
    tick();
    req[3] = 1'b0;
    settle();
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL skip_second got=%b exp=0001", gnt); end
    tick();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 13'd100, 2'b00);
    settle();
    checks++;
    if (gnt !== 4'b0010) begin failures++; $display("FAIL skip_ptr_end got=%b exp=0010", gnt); end
    $display("txn skip final_gnt=%b", gnt);
    tick();
    req = '0;
    settle();
  endtask

  task automatic test_hazard();
    set_req(0, 1'b1, 13'd50, 2'b10);   // leaves the pointer at 1
    settle();
    tick();
    req = '0;
    set_req(1, 1'b1, 13'd7, 2'b01);
    set_req(2, 1'b0, 13'd7, 2'b00);
    settle();
    checks++;
    if (gnt !== 4'b0010) begin failures++; $display("FAIL hazard_write_first got=%b exp=0010", gnt); end
    tick();
    req[1] = 1'b0;
    settle();
    checks++;
    if (gnt !== 4'b0100) begin failures++; $display("FAIL hazard_read_second got=%b exp=0100", gnt); end
    tick();
    req = '0;
    settle();
    checks++;
    if (rvalid !== 4'b0100 || rdata !== 2'b01) begin
      failures++; $display("FAIL hazard_rdata got rvalid=%b rdata=%b exp rvalid=0100 rdata=01", rvalid, rdata);
    end
    $display("txn hazard addr=7 rdata=%b", rdata);
  endtask

  task automatic test_random();
    logic [NREQ-1:0] hold;
    logic [NREQ-1:0] exp_gnt, exp_rv;
    int w;
    hold = '0;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!hold[i] && $urandom_range(0, 1) == 1) begin
          hold[i] = 1'b1;
          set_req(i, 1'($urandom_range(0, 1)), 13'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end
      req = hold;
      settle();
      w       = model_winner(hold, m_ptr);
      exp_gnt = (w < 0) ? 4'b0000 : (4'b0001 << w);
      exp_rv  = (m_pend < 0) ? 4'b0000 : (4'b0001 << m_pend);
      checks += 2;
      if (gnt !== exp_gnt) begin failures++; $display("FAIL rand_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt); end
      if (rvalid !== exp_rv) begin failures++; $display("FAIL rand_rvalid c=%0d got=%b exp=%b", c, rvalid, exp_rv); end
      if (m_pend >= 0) begin
        checks++;
        if (rdata !== m_pdata) begin failures++; $display("FAIL rand_rdata c=%0d got=%b exp=%b", c, rdata, m_pdata); end
      end
      $display("txn rand c=%0d req=%b gnt=%b rvalid=%b rdata=%b", c, req, gnt, rvalid, rdata);
      tick();
      if (w >= 0) hold[w] = 1'b0;
    end
    req = '0;
    settle();
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    set_req(2, 1'b0, 13'd9, 2'b00);
    settle();
    checks++;
    if (gnt !== 4'b0100) begin failures++; $display("FAIL rstmid_gnt got=%b exp=0100", gnt); end
    tick();
    req = '0;
    RST = 1'b1;
    settle();
    checks++;
    if (rvalid !== 4'b0000 || busy !== 1'b1) begin
      failures++; $display("FAIL rstmid_drop got rvalid=%b busy=%b exp rvalid=0000 busy=1", rvalid, busy);
    end
    tick();
    checks++;
    if (rvalid !== 4'b0000) begin failures++; $display("FAIL rstmid_rvalid_after got=%b exp=0000", rvalid); end
    RST = 1'b0;
    settle();
    for (int c = 0; c < 5000; c++) tick();
    checks++;
    if (ram_a !== 13'd5000 || busy !== 1'b1) begin
      failures++; $display("FAIL rstmid_clr_cnt got ram_a=%0d busy=%b exp ram_a=5000 busy=1", ram_a, busy);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    settle();
    n = 0;
    while (busy === 1'b1 && n < 10000) begin
      n++;
      tick();
    end
    checks++;
    if (n != 8192) begin failures++; $display("FAIL rstmid_reclear_cycles got=%0d exp=8192", n); end
    $display("txn reclear cycles=%0d", n);
    set_req(1, 1'b0, 13'd7, 2'b00);
    settle();
    tick();
    req = '0;
    settle();
    checks++;
    if (rvalid !== 4'b0010 || rdata !== 2'b00) begin
      failures++; $display("FAIL rstmid_zeroed got rvalid=%b rdata=%b exp rvalid=0010 rdata=00", rvalid, rdata);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    m_ptr = 0; m_pend = -1; m_clear = 0; m_pdata = 2'b00;
    RST = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    test_reset();
    test_clear();
    test_single();
    test_round_robin();
    test_pointer_skip();
    test_hazard();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_8192x2_port_arbiter.md
# bram_8192x2_port_arbiter

Round-robin arbiter that shares one port of the 8192x2 dual-port block RAM among NREQ requesters. After reset it can also run a clear sequencer that writes zero to every address. It sits between the requester clients and the RAM's port 0 or port 1 signal group (A/D/Q/WE/WEM/CE). It grants at most one access per cycle and returns read data with a per-requester valid strobe.

## Interface
- NREQ, 4, number of requesters (2..8)
- CLEAR_ON_RESET, 1, 1: zero-fill all 8192 words after reset; 0: go straight to service
- CLK  in  1  clock; the RAM port runs on the same clock
- RST  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester access request; held until granted
- we  in  NREQ  per-requester write (1) / read (0) qualifier
- addr  in  13*NREQ  requester i address in bits [13*i+12:13*i]
- wdata  in  2*NREQ  requester i write data in bits [2*i+1:2*i]
- gnt  out  NREQ  one-hot grant, combinational, same cycle as accepted req
- rvalid  out  NREQ  one-hot; read data for requester i valid this cycle
- rdata  out  2  read data, shared by all requesters, qualified by rvalid
- busy  out  1  high while in reset or clearing; no grants while high
- ram_a  out  13  RAM address
- ram_d  out  2  RAM write data
- ram_we  out  1  RAM write enable
- ram_wem  out  2  RAM write mask; always 2'b11
- ram_ce  out  1  RAM chip enable
- ram_q  in  2  RAM read data, one cycle after the access

## Operation
- The state machine has two states: CLEAR and SERVE.
- RST drives the state to CLEAR if CLEAR_ON_RESET=1, otherwise to SERVE. RST also sets clr_cnt=0 and rr_ptr=0, and clears the rvalid pipeline register.
- CLEAR behaviour:
  - Each cycle: ram_ce=1, ram_we=1, ram_a=clr_cnt, ram_d=0; then clr_cnt increments.
  - When clr_cnt==8191 is written, the next state is SERVE.
  - The clear takes exactly 8192 cycles. busy=1 and gnt=0 throughout.
- SERVE, winner selection:
  - Search order is rr_ptr, rr_ptr+1, ... wrapping modulo NREQ.
  - The winner is the first index with req set.
- SERVE, when a winner w exists:
  - gnt[w]=1.
  - ram_ce=1, ram_we=we[w], ram_a=addr[w], ram_d=wdata[w].
  - rr_ptr takes (w+1) mod NREQ at the clock edge.
- SERVE, when no req is set: ram_ce=0, ram_we=0, gnt=0, and rr_ptr holds.
- Read return: a granted read (we[w]=0) sets the registered pending strobe to one-hot w. The next cycle, rvalid[w]=1 and rdata=ram_q.
- Writes never produce rvalid.
- rdata is ram_q passed through directly. It is don't-care when rvalid=0.
- ram_wem is a constant 2'b11. Partial-bit writes are not supported.
- Requesters must hold req, we, addr and wdata stable until they see gnt. A req dropped before grant is simply not served.
- A requester may re-request in the cycle right after its grant. Round-robin rules still apply.

## Timing
- Reset values (during RST and the cycle after):
  - gnt=0, rvalid=0, ram_ce=0, ram_we=0, ram_a=0, ram_d=0, ram_wem=2'b11.
  - busy=CLEAR_ON_RESET.
- Grant latency is 0 cycles: gnt is combinational from req, rr_ptr and state.
- Read latency is 1 cycle: the grant happens at edge k, and rvalid/rdata are valid in cycle k+1.
- Throughput is one access per cycle. Back-to-back reads from different requesters give back-to-back rvalid strobes, each routed to the right requester.
- A read granted in the last SERVE cycle before RST is dropped: RST clears the pending strobe and rvalid=0.
- RST during CLEAR restarts the clear at address 0.
- The first grant is possible in cycle 8192 after RST deasserts (CLEAR_ON_RESET=1), or in cycle 0 (CLEAR_ON_RESET=0).
- Same-address read and write by different requesters are serialized by the arbiter. A read granted after a write returns the new data.

## Test plan
- **Clear:** preload the RAM with 2'b11, pulse RST, count busy cycles (must be 8192), then read addresses 0, 4095 and 8191. Required: all read 2'b00, and ram_we pulses exactly 8192 times.
- **Single requester:** req0 writes 2'b10 to address 13'h1ABC, then reads it. Required: gnt0 in the same cycle as each request, rvalid[0]=1 with rdata=2'b10 one cycle after the read grant.
- **Round-robin fairness:** all 4 requesters hold req for 8 cycles with reads. Required: grant order is 0,1,2,3,0,1,2,3. Each requester gets exactly 2 grants, and rvalid follows the grant pattern one cycle later.
- **Pointer skip:** rr_ptr=1, only req0 and req3 set. Required: grant 3 first, then 0; rr_ptr ends at 1.
- **Reset mid-operation:** assert RST in the cycle a read is granted to requester 2. Required: rvalid stays 0 in the following cycle and busy=1. Asserting RST at clr_cnt=5000 restarts the clear, which then lasts a full 8192 cycles.
- **Write-then-read hazard:** requester 1 writes 2'b01 to address 7 while requester 2 requests a read of address 7 in the same cycle (rr_ptr=1). Required: the write is granted first, and requester 2's rvalid carries rdata=2'b01.
